// File: rtl/morse_pkg.sv
// morse_pkg: symbol codes and detector FSM encoding shared with the character decoder
package morse_pkg;
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_CHAR = 2'b11;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/morse_symbol_detector_if.sv
// morse_symbol_detector_if: raw button in, registered symbol pulse out
interface morse_symbol_detector_if;
  logic       serial_inp;
  logic [1:0] parallel_out;
  modport master(output serial_inp, input parallel_out);
  modport slave(input serial_inp, output parallel_out);
endinterface

// File: rtl/morse_debouncer.sv
// morse_debouncer: 2-FF synchroniser followed by a stability counter
module morse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]    s;
  logic [DW-1:0] cnt;
  logic          diff;
  assign diff = s[1] != dout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s   <= {s[0], din};
      cnt <= (diff && cnt != LAST) ? cnt + 1'b1 : '0;
      if (diff && cnt == LAST) dout <= s[1];
    end
  end
endmodule

// File: rtl/morse_symbol_detector.sv
// morse_symbol_detector: debounces the button and classifies presses/gaps into symbol pulses
module morse_symbol_detector
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DOT_MAX_CYCLES  = 25_000_000,
  parameter int CHAR_GAP_CYCLES = 60_000_000
) (
  input logic                     clk,
  input logic                     rst_n,
  morse_symbol_detector_if.slave  bus
);
  localparam int CNT_W = $clog2(imax(DOT_MAX_CYCLES, CHAR_GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DOT_MAX = CNT_W'(DOT_MAX_CYCLES);
  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(CHAR_GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  logic             btn;
  state_t           state, state_n;
  logic [CNT_W-1:0] press_cnt, press_n, gap_cnt, gap_n;
  logic [1:0]       sym, sym_n;
  morse_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk (clk),
    .rst_n(rst_n),
    .din (bus.serial_inp),
    .dout(btn)
  );
  assign bus.parallel_out = sym;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
      sym       <= SYM_NONE;
    end else begin
      state     <= state_n;
      press_cnt <= press_n;
      gap_cnt   <= gap_n;
      sym       <= sym_n;
    end
  end
  // A new press in GAP takes priority over gap expiry, so no char space is emitted then
  always_comb begin
    state_n = state;
    press_n = press_cnt;
    gap_n   = gap_cnt;
    sym_n   = SYM_NONE;
    unique case (state)
      IDLE: if (btn) begin
        state_n = PRESS;
        press_n = ONE;
      end
      PRESS: if (!btn) begin
        sym_n   = press_cnt < DOT_MAX ? SYM_DOT : SYM_DASH;
        state_n = GAP;
        gap_n   = ONE;
      end else press_n = press_cnt == DOT_MAX ? press_cnt : press_cnt + 1'b1;
      GAP: if (btn) begin
        state_n = PRESS;
        press_n = ONE;
      end else if (gap_cnt == GAP_MAX) begin
        sym_n   = SYM_CHAR;
        state_n = IDLE;
      end else gap_n = gap_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule
